// File: rtl/note_tone_gen.sv
// Square-wave tone generator: turns the sequencer's 5-bit note index into a
// speaker drive at the matching pitch, with rests, enable gating and clean retunes.
module note_tone_gen #(
    parameter int REST_MIN  = 24,
    parameter int SIM_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [4:0] note,
    output logic       spk,
    output logic       playing
);

    localparam int         CW     = 17;
    localparam logic [4:0] REST_Q = 5'(REST_MIN);

    logic [4:0]    note_q;
    logic [CW-1:0] cnt;
    logic [4:0]    semi;
    logic [4:0]    oct;
    logic [CW-1:0] base;
    logic [CW-1:0] shifted;
    logic [CW-1:0] half;
    logic          change;
    logic          rest_q;
    logic          rest_new;
    logic          terminal;

    // Half-period counts at 50 MHz for the lowest octave, A3 upward.
    function automatic logic [CW-1:0] base_count(input logic [4:0] s);
        logic [CW-1:0] r;
        case (s)
            5'd0:    r = 17'd113636;
            5'd1:    r = 17'd107258;
            5'd2:    r = 17'd101239;
            5'd3:    r = 17'd95556;
            5'd4:    r = 17'd90193;
            5'd5:    r = 17'd85131;
            5'd6:    r = 17'd80353;
            5'd7:    r = 17'd75843;
            5'd8:    r = 17'd71586;
            5'd9:    r = 17'd67568;
            5'd10:   r = 17'd63776;
            5'd11:   r = 17'd60196;
            default: r = 17'd113636;
        endcase
        return r;
    endfunction

    always_comb begin
        semi     = note_q % 5'd12;
        oct      = note_q / 5'd12;
        base     = base_count(semi);
        shifted  = base >> (int'(oct) + SIM_SHIFT);
        half     = (shifted < 17'd2) ? 17'd2 : shifted;
        change   = (note != note_q);
        rest_q   = (note_q >= REST_Q);
        rest_new = (note >= REST_Q);
        terminal = (cnt == half - 17'd1);
    end

    // NOTE: state is updated with non-blocking assignments so every branch
    // sees the pre-edge values of cnt/spk, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_q  <= REST_Q;
            cnt     <= '0;
            spk     <= 1'b0;
            playing <= 1'b0;
        end else begin
            note_q <= note;
            if (!en) begin
                cnt     <= '0;
                spk     <= 1'b0;
                playing <= 1'b0;
            end else if (change) begin
                // Retune restarts the count; a coinciding terminal count is dropped.
                cnt     <= '0;
                spk     <= rest_new ? 1'b0 : spk;
                playing <= ~rest_new;
            end else if (rest_q) begin
                cnt     <= '0;
                spk     <= 1'b0;
                playing <= 1'b0;
            end else begin
                playing <= 1'b1;
                if (terminal) begin
                    cnt <= '0;
                    spk <= ~spk;
                end else begin
                    cnt <= cnt + 17'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen with SIM_SHIFT=10; half-periods below are
// hand-derived as BASE[semi] >> (oct + 10).
module tb_note_tone_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [4:0] note;
    logic       spk;
    logic       playing;

    int vectors;
    int miscompares;

    note_tone_gen #(.REST_MIN(24), .SIM_SHIFT(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .note    (note),
        .spk     (spk),
        .playing (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Count clock edges until spk changes level (bounded).
    task automatic wait_change(output int n);
        logic s;
        s = spk;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (spk == s && n < 400);
    endtask

    // Count cycles with spk high over a window.
    task automatic count_high(input int cycles, output int highs);
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (spk) highs++;
        end
    endtask

    typedef struct {
        logic [4:0] n;
        int         h;
    } step_t;

    step_t steps[8];

    initial begin
        int n;
        int highs;
        logic s;
        vectors     = 0;
        miscompares = 0;
        steps[0] = '{5'd0, 110};
        steps[1] = '{5'd4, 88};
        steps[2] = '{5'd7, 74};
        steps[3] = '{5'd12, 55};
        steps[4] = '{5'd24, 0};
        steps[5] = '{5'd19, 37};
        steps[6] = '{5'd30, 0};
        steps[7] = '{5'd23, 29};

        // Reset held with a playable note presented
        rst_n = 1'b0;
        en    = 1'b1;
        note  = 5'd0;
        repeat (4) @(negedge clk);
        check("rst_spk", spk, 0);
        check("rst_playing", playing, 0);
        check("rst_cnt", dut.cnt, 0);

        // A3 at H=110: register edge + 110 to first rise, then 110 per half
        rst_n = 1'b1;
        wait_change(n);
        check("a3_first_rise", n, 111);
        check("a3_playing", playing, 1);
        wait_change(n);
        check("a3_high_time", n, 110);
        wait_change(n);
        check("a3_low_time", n, 110);
        check("a3_spk_high", spk, 1);

        // Asynchronous reset mid-note, observed before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_spk", spk, 0);
        check("async_rst_playing", playing, 0);
        check("async_rst_cnt", dut.cnt, 0);

        // Note 23: H = 60196 >> 11 = 29
        @(negedge clk);
        note  = 5'd23;
        rst_n = 1'b1;
        wait_change(n);
        check("n23_first_rise", n, 30);
        wait_change(n);
        check("n23_high_time", n, 29);
        wait_change(n);
        check("n23_low_time", n, 29);

        // Retune to 18 (H=39), then rest 25
        note = 5'd18;
        wait_change(n);
        check("n18_first_change", n, 40);
        note = 5'd25;
        repeat (2) @(negedge clk);
        check("rest_spk", spk, 0);
        check("rest_playing", playing, 0);
        count_high(20, highs);
        check("rest_held_low", highs, 0);
        note = 5'd18;
        wait_change(n);
        check("rest_exit_rise", n, 40);
        check("rest_exit_spk", spk, 1);

        // Collision: change lands on the cnt == H-1 edge
        repeat (38) @(negedge clk);
        check("coll_cnt_pre", dut.cnt, 38);
        s    = spk;
        note = 5'd0;
        @(negedge clk);
        check("coll_no_toggle", spk, s);
        check("coll_cnt_cleared", dut.cnt, 0);
        wait_change(n);
        check("coll_next_toggle", n, 110);

        // Held note 13 (H=52): continuous wave with no retrigger
        note = 5'd13;
        wait_change(n);
        check("n13_first_change", n, 53);
        for (int i = 0; i < 6; i++) begin
            wait_change(n);
            check($sformatf("n13_half_%0d", i), n, 52);
        end

        // Enable gating
        en = 1'b0;
        repeat (5) @(negedge clk);
        check("en0_spk", spk, 0);
        check("en0_playing", playing, 0);
        check("en0_cnt", dut.cnt, 0);
        en = 1'b1;
        wait_change(n);
        check("en1_first_toggle", n, 52);

        // Sequencer step sequence
        foreach (steps[k]) begin
            note = steps[k].n;
            if (steps[k].h == 0) begin
                repeat (2) @(negedge clk);
                check($sformatf("seq%0d_rest_spk", k), spk, 0);
                check($sformatf("seq%0d_rest_playing", k), playing, 0);
                count_high(30, highs);
                check($sformatf("seq%0d_rest_silent", k), highs, 0);
            end else begin
                wait_change(n);
                check($sformatf("seq%0d_first", k), n, 1 + steps[k].h);
                wait_change(n);
                check($sformatf("seq%0d_half_a", k), n, steps[k].h);
                wait_change(n);
                check($sformatf("seq%0d_half_b", k), n, steps[k].h);
                check($sformatf("seq%0d_playing", k), playing, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Downstream stage of the melody sequencer in music_engine.
- Consumes the 5-bit note index the sequencer holds for each ~0.1 s step and drives a square-wave speaker pin at that pitch.
- Handles rests, enable gating and glitch-free pitch changes, so the sequencer output can be wired straight in.

Parameters:
- REST_MIN, 24, note indices >= REST_MIN are rests (speaker silent).
- SIM_SHIFT, 0, extra right-shift applied to every half-period count; sim benches only, 0 in silicon.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  1 = play; 0 = silence and hold the counter cleared.
- note  input  5  note index from the sequencer: 0..23 are semitones from A3 upward, 24..31 are rests.
- spk  output  1  square-wave speaker drive.
- playing  output  1  1 while a non-rest note is sounding with en = 1.

Behaviour:
- Reset (rst_n low, asynchronous), all cleared:
  - note_q = REST_MIN (5'd24)
  - cnt = 0
  - spk = 0
  - playing = 0
- Input register: note_q is updated from note every clock. A change is detected when note != note_q at the rising edge.
- Pitch decode (combinational from note_q):
  - semi = note_q mod 12; oct = note_q / 12 (0 or 1).
  - H = BASE[semi] >> (oct + SIM_SHIFT).
  - BASE half-period counts at 50 MHz, semi 0..11: 113636, 107258, 101239, 95556, 90193, 85131, 80353, 75843, 71586, 67568, 63776, 60196.
  - cnt is 17 bits; all arithmetic is unsigned. Any H < 2 is clamped to 2.
- Rest or disabled (note_q >= REST_MIN or en = 0):
  - Next edge: cnt <= 0, spk <= 0, playing <= 0.
- Sounding:
  - playing <= 1.
  - If cnt == H-1: cnt <= 0 and spk <= ~spk. Otherwise cnt <= cnt+1.
  - Resulting output period is 2H cycles at 50% duty. A3 gives 227272 cycles, i.e. 220.0 Hz.
- Note change (edge where note != note_q):
  - cnt <= 0.
  - spk keeps its level if the new note is a non-rest; spk <= 0 if the new note is a rest.
  - The new H applies from the next cycle. No runt pulse shorter than one full new half-period may be produced, except the first half-period after a change.
  - If a change and the terminal count coincide on the same edge, the change wins: cnt <= 0 and no toggle.
- Same note held across sequencer steps: no retrigger. cnt and spk run continuously.
- en deasserted mid-note: silence on the next edge. On re-enable, spk starts low and the first toggle occurs H cycles later.
- Reset asserted mid-note: outputs go to their reset values immediately (asynchronous). After release, the first toggle occurs H cycles after the current note is registered.
- Latency:
  - note input to first spk rise: 1 cycle to register, plus H cycles.
  - en or rest input to spk = 0: at most 2 cycles.

Test Plan:
- Reset: hold rst_n=0 with note=0 and en=1 -> spk=0, playing=0, cnt=0. Then assert rst_n=0 asynchronously mid-toggle -> spk drops immediately without waiting for a clock.
- Pitch accuracy (SIM_SHIFT=10): note=0, en=1 -> H=110, spk high/low every 110 cycles, period 220. Then note=23 -> H = 60196>>11 = 29, period 58.
- Rest: note 18 -> 25 -> spk=0 and playing=0 within 2 cycles and held low. Return to 18 -> first spk rise H cycles after the registered change.
- Note change collision: change note on the exact cycle cnt==H-1 -> no toggle on that edge; the next toggle arrives after the new H cycles.
- Held note / enable: note=13 held for 3 steps -> uninterrupted 50% wave with no phase jump. en=0 for 5 cycles -> spk=0 and cnt=0; en=1 -> first toggle after H cycles.
- Sequencer integration: drive the 0.1 s step sequence (SIM_SHIFT=10, shortened step) -> spk frequency matches the decoded H for every step, silent on every index >= 24.
